// File: rtl/timer_dev_if.sv
// Peripheral bus between the CPU (master) and a timer device (slave):
// word write strobe/address/data in, combinational read data and IRQ out.
interface timer_dev_if;
    logic        We;
    logic [31:0] ADDR;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    modport master (output We, ADDR, WD, input RD, IRQ);
    modport slave  (input We, ADDR, WD, output RD, IRQ);
endinterface

// File: rtl/timer_dev.sv
// Countdown timer peripheral: CTRL/PRESET/COUNT registers, one-shot or
// auto-reload, interrupt flag masked by CTRL.IM.
module timer_dev #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    timer_dev_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_q, irq_d;

    logic        hit;
    logic [1:0]  off;
    logic        en, im, auto_reload;
    logic        unused_addr;

    assign hit         = (bus.ADDR[31:4] == BASE[31:4]);
    assign off         = bus.ADDR[3:2];
    assign unused_addr = ^bus.ADDR[1:0];
    assign en          = ctrl_q[0];
    assign im          = ctrl_q[3];
    assign auto_reload = (ctrl_q[2:1] == 2'b01);

    always_comb begin
        bus.RD = '0;
        if (hit) begin
            case (off)
                OFF_CTRL:   bus.RD = {28'b0, ctrl_q};
                OFF_PRESET: bus.RD = preset_q;
                OFF_COUNT:  bus.RD = count_q;
                default:    bus.RD = '0;
            endcase
        end
    end

    assign bus.IRQ = irq_q & im;

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;

        case (state_q)
            IDLE: if (en) state_d = LOAD;
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = '0;
                    irq_d   = 1'b1;
                    state_d = INT;
                end
            end
            INT: begin
                if (auto_reload) begin
                    irq_d   = 1'b0;
                    state_d = LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus writes come last so they override same-edge FSM updates to
        // CTRL and irq_flag.
        if (bus.We && hit) begin
            case (off)
                OFF_CTRL: begin
                    ctrl_d = bus.WD[3:0];
                    irq_d  = 1'b0;
                end
                OFF_PRESET: begin
                    preset_d = bus.WD;
                    irq_d    = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end
endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: register access, one-shot, auto-reload,
// masking, boundaries and async reset.
module tb_timer_dev;
    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_PRE  = BASE + 32'h4;
    localparam logic [31:0] A_CNT  = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [31:0] r;

    timer_dev_if bus();

    timer_dev #(.BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge and the
    // task returns at the next negedge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.We = 1'b1; bus.ADDR = a; bus.WD = d;
        @(negedge clk);
        bus.We = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.ADDR = a;
        #1;
        d = bus.RD;
    endtask

    initial begin
        bus.We = 1'b0; bus.ADDR = '0; bus.WD = '0;

        // reset state and miss handling
        repeat (2) @(negedge clk);
        rd(A_CTRL, r); chk("rst_ctrl", r, 0);
        rd(A_PRE, r);  chk("rst_pre", r, 0);
        rd(A_CNT, r);  chk("rst_cnt", r, 0);
        rd(A_RSV, r);  chk("rst_rsv", r, 0);
        chk("rst_irq", bus.IRQ, 0);
        reset = 1'b0;
        @(negedge clk);
        wr(BASE + 32'h10, 32'hF);
        wr(BASE + 32'h14, 32'h1234);
        rd(A_CTRL, r); chk("miss_ctrl", r, 0);
        rd(A_PRE, r);  chk("miss_pre", r, 0);
        rd(BASE + 32'h10, r); chk("miss_rd", r, 0);
        wr(A_RSV, 32'hFF);
        rd(A_RSV, r); chk("rsv_rd", r, 0);
        wr(A_CNT, 32'h55);
        rd(A_CNT, r); chk("cnt_ro", r, 0);

        // one-shot, PRESET=5, IM=1
        wr(A_PRE, 32'd5);
        rd(A_PRE, r); chk("pre_rd", r, 5);
        wr(A_CTRL, 32'h9);
        @(negedge clk);
        for (int i = 2; i <= 7; i++) begin
            @(negedge clk);
            rd(A_CNT, r); chk("os_cnt", r, 32'(7 - i));
            chk("os_irq", bus.IRQ, (i == 7) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        rd(A_CTRL, r); chk("os_en_clr", r, 8);
        chk("os_irq_hold", bus.IRQ, 1);
        repeat (3) @(negedge clk);
        chk("os_irq_hold2", bus.IRQ, 1);
        wr(A_CTRL, 32'h8);
        chk("os_irq_clr", bus.IRQ, 0);

        // auto-reload, PRESET=3: pulses every 5 edges
        wr(A_PRE, 32'd3);
        wr(A_CTRL, 32'hB);
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            chk("ar_irq", bus.IRQ, (i % 5 == 0) ? 32'd1 : 32'd0);
            if (i % 5 == 2) begin
                rd(A_CNT, r); chk("ar_reload", r, 3);
            end
        end
        wr(A_CTRL, 32'h0);
        @(negedge clk);

        // masked: flag sets, IRQ stays low, one-shot clears EN
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("mask_irq", bus.IRQ, 0);
        end
        rd(A_CTRL, r); chk("mask_en_clr", r, 0);
        rd(A_CNT, r);  chk("mask_cnt", r, 0);

        // stop mid-count freezes COUNT
        wr(A_PRE, 32'd10);
        wr(A_CTRL, 32'h9);
        repeat (4) @(negedge clk);
        rd(A_CNT, r); chk("stop_pre", r, 8);
        wr(A_CTRL, 32'h8);
        repeat (5) @(negedge clk);
        rd(A_CNT, r); chk("stop_cnt", r, 7);
        chk("stop_irq", bus.IRQ, 0);

        // PRESET=0 auto-reload: period 3
        wr(A_PRE, 32'd0);
        wr(A_CTRL, 32'hB);
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            chk("p0_irq", bus.IRQ, (i % 3 == 0) ? 32'd1 : 32'd0);
        end
        wr(A_CTRL, 32'h0);
        @(negedge clk);

        // max PRESET
        wr(A_PRE, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rd(A_CNT, r); chk("max_load", r, 32'hFFFF_FFFF);
        @(negedge clk);
        rd(A_CNT, r); chk("max_dec1", r, 32'hFFFF_FFFE);
        @(negedge clk);
        rd(A_CNT, r); chk("max_dec2", r, 32'hFFFF_FFFD);
        wr(A_CTRL, 32'h0);
        @(negedge clk);

        // CTRL write on the INT edge wins over the one-shot EN clear
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'h9);
        repeat (4) @(negedge clk);
        chk("int_irq", bus.IRQ, 1);
        wr(A_CTRL, 32'hD);
        rd(A_CTRL, r); chk("int_ctrl_kept", r, 32'hD);
        chk("int_irq_clr", bus.IRQ, 0);
        // restarted run: PRESET write on the flag-set edge wins
        repeat (3) @(negedge clk);
        wr(A_PRE, 32'd4);
        chk("set_edge_irq", bus.IRQ, 0);
        rd(A_CNT, r); chk("set_edge_cnt", r, 0);
        @(negedge clk);
        rd(A_CTRL, r); chk("set_edge_ctrl", r, 32'hC);
        chk("set_edge_irq2", bus.IRQ, 0);
        wr(A_CTRL, 32'h0);

        // async reset mid-count
        wr(A_PRE, 32'd20);
        wr(A_CTRL, 32'h9);
        repeat (15) @(negedge clk);
        rd(A_CNT, r); chk("ar_pre_cnt", r, 7);
        @(negedge clk);
        reset = 1'b1;
        #1;
        rd(A_CNT, r);  chk("arst_cnt", r, 0);
        rd(A_CTRL, r); chk("arst_ctrl", r, 0);
        chk("arst_irq", bus.IRQ, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        rd(A_CNT, r);  chk("post_cnt", r, 0);
        rd(A_CTRL, r); chk("post_ctrl", r, 0);
        chk("post_irq", bus.IRQ, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
